ra_2r1w_32x32_ctl: RTL and testbench

//  Front-end controller for the 2R1W 32x32 SDR register array. Arbitrates NUM_RD read requesters

---
 rtl/ra_ctl_pkg.sv | 19 +
 rtl/ra_2r1w_32x32_ctl_if.sv | 26 ++
 rtl/ra_rr_pick2.sv | 37 +++
 rtl/ra_2r1w_32x32_ctl.sv | 145 ++++++++++++++
 tb/tb_ra_2r1w_32x32_ctl.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/ra_ctl_pkg.sv
// Shared types for the 2R1W register-array front-end controller.
package ra_ctl_pkg;

  localparam int unsigned DEF_ADR_W = 5;
  localparam int unsigned DEF_DAT_W = 32;
  // Wide enough for the largest supported requester count (8).
  localparam int unsigned ID_W      = 3;

  typedef enum logic [0:0] {StInit, StRun} state_e;

  // One in-flight read; bypass data travels alongside in its own pipe.
  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
    logic            port;
    logic            byp;
  } rsp_ent_t;

endpackage

// File: rtl/ra_2r1w_32x32_ctl_if.sv
// Client-side bus of the register-array controller: read requests/responses and the write port.
interface ra_2r1w_32x32_ctl_if #(
  parameter int unsigned NUM_RD = 4,
  parameter int unsigned ADR_W  = 5,
  parameter int unsigned DAT_W  = 32
);
  logic [NUM_RD-1:0]       rd_req_vld;
  logic [NUM_RD*ADR_W-1:0] rd_req_adr;
  logic [NUM_RD-1:0]       rd_req_rdy;
  logic [NUM_RD-1:0]       rd_rsp_vld;
  logic [NUM_RD*DAT_W-1:0] rd_rsp_dat;
  logic                    wr_req_vld;
  logic [ADR_W-1:0]        wr_req_adr;
  logic [DAT_W-1:0]        wr_req_dat;
  logic                    wr_req_rdy;

  modport master (
    output rd_req_vld, rd_req_adr, wr_req_vld, wr_req_adr, wr_req_dat,
    input  rd_req_rdy, rd_rsp_vld, rd_rsp_dat, wr_req_rdy
  );

  modport slave (
    input  rd_req_vld, rd_req_adr, wr_req_vld, wr_req_adr, wr_req_dat,
    output rd_req_rdy, rd_rsp_vld, rd_rsp_dat, wr_req_rdy
  );
endinterface

// File: rtl/ra_rr_pick2.sv
// Combinational round-robin picker: first and second valid requester at or after ptr_i.
module ra_rr_pick2 #(
  parameter  int unsigned NUM_RD = 4,
  localparam int unsigned IDX_W  = $clog2(NUM_RD)
) (
  input  logic [NUM_RD-1:0] vld_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic              gnt0_vld_o,
  output logic [IDX_W-1:0]  gnt0_idx_o,
  output logic              gnt1_vld_o,
  output logic [IDX_W-1:0]  gnt1_idx_o
);

  logic [IDX_W:0] idx;

  always_comb begin
    gnt0_vld_o = 1'b0;
    gnt0_idx_o = '0;
    gnt1_vld_o = 1'b0;
    gnt1_idx_o = '0;
    idx        = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      idx = {1'b0, ptr_i} + (IDX_W+1)'(k);
      if (idx >= (IDX_W+1)'(NUM_RD)) idx = idx - (IDX_W+1)'(NUM_RD);
      if (vld_i[idx[IDX_W-1:0]]) begin
        if (!gnt0_vld_o) begin
          gnt0_vld_o = 1'b1;
          gnt0_idx_o = idx[IDX_W-1:0];
        end else if (!gnt1_vld_o) begin
          gnt1_vld_o = 1'b1;
          gnt1_idx_o = idx[IDX_W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/ra_2r1w_32x32_ctl.sv
// Front-end controller for the 2R1W register array: zero-fill after reset, 2-of-N read
// arbitration, write pass-through and per-requester responses with write-first bypass.
module ra_2r1w_32x32_ctl
  import ra_ctl_pkg::*;
#(
  parameter int unsigned NUM_RD = 4,
  parameter int unsigned ADR_W  = DEF_ADR_W,
  parameter int unsigned DAT_W  = DEF_DAT_W,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  ra_2r1w_32x32_ctl_if.slave      bus,
  output logic                    busy,
  output logic                    strobe,
  output logic                    rd_enb_0,
  output logic [ADR_W-1:0]        rd_adr_0,
  input  logic [DAT_W-1:0]        rd_dat_0,
  output logic                    rd_enb_1,
  output logic [ADR_W-1:0]        rd_adr_1,
  input  logic [DAT_W-1:0]        rd_dat_1,
  output logic                    wr_enb_0,
  output logic [ADR_W-1:0]        wr_adr_0,
  output logic [DAT_W-1:0]        wr_dat_0
);

  localparam int unsigned IDX_W = $clog2(NUM_RD);

  state_e           state_q;
  logic [ADR_W-1:0] cnt_q;
  logic [IDX_W-1:0] ptr_q, ptr_d, last_idx;

  logic             run, init_act, wr_go;
  logic             g0_vld, g1_vld;
  logic [IDX_W-1:0] g0_idx, g1_idx;

  rsp_ent_t         ent_d  [2];
  rsp_ent_t         pipe_q [RD_LAT][2];
  logic [DAT_W-1:0] byp_dat_q [RD_LAT];
  logic [DAT_W-1:0] rsp_dat_q [NUM_RD];
  logic [DAT_W-1:0] rsp_dat_d [NUM_RD];
  logic [NUM_RD-1:0] rsp_vld;

  // Gating with reset keeps every output quiet during the reset cycle itself.
  assign run      = (state_q == StRun) && !reset;
  assign init_act = (state_q == StInit) && !reset;
  assign wr_go    = run && bus.wr_req_vld;

  ra_rr_pick2 #(.NUM_RD(NUM_RD)) u_pick (
    .vld_i      (bus.rd_req_vld & {NUM_RD{run}}),
    .ptr_i      (ptr_q),
    .gnt0_vld_o (g0_vld),
    .gnt0_idx_o (g0_idx),
    .gnt1_vld_o (g1_vld),
    .gnt1_idx_o (g1_idx)
  );

  always_comb begin
    bus.rd_req_rdy = '0;
    if (g0_vld) bus.rd_req_rdy[g0_idx] = 1'b1;
    if (g1_vld) bus.rd_req_rdy[g1_idx] = 1'b1;
  end

  assign rd_enb_0       = g0_vld;
  assign rd_adr_0       = bus.rd_req_adr[g0_idx*ADR_W +: ADR_W];
  assign rd_enb_1       = g1_vld;
  assign rd_adr_1       = bus.rd_req_adr[g1_idx*ADR_W +: ADR_W];
  assign wr_enb_0       = init_act || wr_go;
  assign wr_adr_0       = init_act ? cnt_q : bus.wr_req_adr;
  assign wr_dat_0       = init_act ? '0 : bus.wr_req_dat;
  assign strobe         = rd_enb_0 || rd_enb_1 || wr_enb_0;
  assign busy           = init_act;
  assign bus.wr_req_rdy = run;

  assign last_idx = g1_vld ? g1_idx : g0_idx;
  assign ptr_d    = (last_idx == IDX_W'(NUM_RD - 1)) ? '0 : last_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StInit;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      unique case (state_q)
        StInit: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == '1) state_q <= StRun;
        end
        StRun: if (g0_vld) ptr_q <= ptr_d;
        default: state_q <= StInit;
      endcase
    end
  end

  always_comb begin
    ent_d[0].vld  = g0_vld;
    ent_d[0].id   = ID_W'(g0_idx);
    ent_d[0].port = 1'b0;
    ent_d[0].byp  = g0_vld && wr_go && (rd_adr_0 == bus.wr_req_adr);
    ent_d[1].vld  = g1_vld;
    ent_d[1].id   = ID_W'(g1_idx);
    ent_d[1].port = 1'b1;
    ent_d[1].byp  = g1_vld && wr_go && (rd_adr_1 == bus.wr_req_adr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned s = 0; s < RD_LAT; s++) begin
        for (int p = 0; p < 2; p++) pipe_q[s][p] <= '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        pipe_q[0][p] <= ent_d[p];
        for (int unsigned s = 1; s < RD_LAT; s++) pipe_q[s][p] <= pipe_q[s-1][p];
      end
    end
  end

  always_ff @(posedge clk) begin
    byp_dat_q[0] <= bus.wr_req_dat;
    for (int unsigned s = 1; s < RD_LAT; s++) byp_dat_q[s] <= byp_dat_q[s-1];
    for (int unsigned i = 0; i < NUM_RD; i++) rsp_dat_q[i] <= rsp_dat_d[i];
  end

  // Non-responding requesters keep presenting their previous data.
  always_comb begin
    rsp_vld = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) rsp_dat_d[i] = rsp_dat_q[i];
    for (int p = 0; p < 2; p++) begin
      for (int unsigned i = 0; i < NUM_RD; i++) begin
        if (!reset && pipe_q[RD_LAT-1][p].vld && (pipe_q[RD_LAT-1][p].id == ID_W'(i))) begin
          rsp_vld[i]   = 1'b1;
          rsp_dat_d[i] = pipe_q[RD_LAT-1][p].byp  ? byp_dat_q[RD_LAT-1] :
                         pipe_q[RD_LAT-1][p].port ? rd_dat_1 : rd_dat_0;
        end
      end
    end
  end

  always_comb begin
    bus.rd_rsp_vld = rsp_vld;
    for (int unsigned i = 0; i < NUM_RD; i++) bus.rd_rsp_dat[i*DAT_W +: DAT_W] = rsp_dat_d[i];
  end

endmodule

// File: tb/tb_ra_2r1w_32x32_ctl.sv
// Scoreboard bench for ra_2r1w_32x32_ctl with a behavioural 32x32 array (read latency 1).
module tb_ra_2r1w_32x32_ctl;

  localparam int NUM_RD = 4;
  localparam int ADR_W  = 5;
  localparam int DAT_W  = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ra_2r1w_32x32_ctl_if #(.NUM_RD(NUM_RD), .ADR_W(ADR_W), .DAT_W(DAT_W)) bus ();

  logic             busy, strobe;
  logic             rd_enb_0, rd_enb_1, wr_enb_0;
  logic [ADR_W-1:0] rd_adr_0, rd_adr_1, wr_adr_0;
  logic [DAT_W-1:0] rd_dat_0, rd_dat_1, wr_dat_0;
  logic [DAT_W-1:0] mem [32];

  ra_2r1w_32x32_ctl #(.NUM_RD(NUM_RD), .ADR_W(ADR_W), .DAT_W(DAT_W), .RD_LAT(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .busy     (busy),
    .strobe   (strobe),
    .rd_enb_0 (rd_enb_0),
    .rd_adr_0 (rd_adr_0),
    .rd_dat_0 (rd_dat_0),
    .rd_enb_1 (rd_enb_1),
    .rd_adr_1 (rd_adr_1),
    .rd_dat_1 (rd_dat_1),
    .wr_enb_0 (wr_enb_0),
    .wr_adr_0 (wr_adr_0),
    .wr_dat_0 (wr_dat_0)
  );

  // Array model: reads return the pre-write contents on a same-address collision.
  always @(posedge clk) begin
    if (rd_enb_0) rd_dat_0 <= mem[rd_adr_0];
    if (rd_enb_1) rd_dat_1 <= mem[rd_adr_1];
    if (wr_enb_0) mem[wr_adr_0] <= wr_dat_0;
  end

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] exp_q [NUM_RD][$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every response pops its requester's queue.
  always @(negedge clk) begin
    for (int i = 0; i < NUM_RD; i++) begin
      if (bus.rd_rsp_vld[i] === 1'b1) begin
        if (exp_q[i].size() == 0) begin
          n_chk++;
          $display("FAIL rsp_unexpected[%0d]: got rsp_vld=1 expected none", i);
        end else begin
          chk($sformatf("rsp_dat[%0d]", i), bus.rd_rsp_dat[i*DAT_W +: DAT_W], exp_q[i].pop_front());
        end
      end
    end
  end

  function automatic logic [19:0] adr4(input int a3, input int a2, input int a1, input int a0);
    return {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic [3:0] vld, input logic [19:0] adrs, input logic wv,
                     input int wa, input logic [31:0] wd);
    bus.rd_req_vld = vld;
    bus.rd_req_adr = adrs;
    bus.wr_req_vld = wv;
    bus.wr_req_adr = 5'(wa);
    bus.wr_req_dat = wd;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(4'hF, adr4(3, 2, 1, 0), 1'b1, 7, 32'h1234);
    chk("rst_busy",   32'(busy), 32'd0);
    chk("rst_strobe", 32'(strobe), 32'd0);
    chk("rst_wr_enb", 32'(wr_enb_0), 32'd0);
    chk("rst_rd_rdy", 32'(bus.rd_req_rdy), 32'd0);
    chk("rst_wr_rdy", 32'(bus.wr_req_rdy), 32'd0);
    chk("rst_rsp",    32'(bus.rd_rsp_vld), 32'd0);
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic init_sweep();
    int bad = 0;
    for (int k = 0; k < 32; k++) begin
      cyc(4'hF, adr4(3, 2, 1, 0), 1'b1, 31, 32'hFFFF_FFFF);
      if (busy !== 1'b1 || wr_enb_0 !== 1'b1 || wr_adr_0 !== 5'(k) || wr_dat_0 !== 32'd0 ||
          bus.rd_req_rdy !== 4'd0 || bus.wr_req_rdy !== 1'b0 || rd_enb_0 !== 1'b0) bad++;
      if (k == 0) chk("init_first_adr", 32'(wr_adr_0), 32'd0);
      step();
    end
    chk("init_sweep_bad_cycles", 32'(bad), 32'd0);
    cyc(4'h0, 20'd0, 1'b0, 0, 32'd0);
    chk("run_busy", 32'(busy), 32'd0);
    chk("run_wr_rdy", 32'(bus.wr_req_rdy), 32'd1);
    step();
  endtask

  initial begin
    do_reset();
    init_sweep();

    // Preload 16..19 with 0x1000+i.
    for (int i = 0; i < 4; i++) begin
      cyc(4'h0, 20'd0, 1'b1, 16 + i, 32'h1000 + 32'(i));
      chk("pre_wr_adr", 32'(wr_adr_0), 32'(16 + i));
      step();
    end

    // Only req3 valid at p=0: port 0, port 1 idle, pointer wraps to 0.
    cyc(4'b1000, adr4(19, 0, 0, 0), 1'b0, 0, 32'd0);
    chk("t5_rdy", 32'(bus.rd_req_rdy), 32'b1000);
    chk("t5_adr0", 32'(rd_adr_0), 32'd19);
    chk("t5_enb1", 32'(rd_enb_1), 32'd0);
    chk("t5_strobe", 32'(strobe), 32'd1);
    exp_q[3].push_back(32'h1003);
    step();

    // All valid from p=0: {0,1},{2,3},{0,1}.
    for (int c = 0; c < 3; c++) begin
      cyc(4'hF, adr4(19, 18, 17, 16), 1'b0, 0, 32'd0);
      chk("t3_rdy", 32'(bus.rd_req_rdy), (c == 1) ? 32'b1100 : 32'b0011);
      chk("t3_adr0", 32'(rd_adr_0), (c == 1) ? 32'd18 : 32'd16);
      chk("t3_adr1", 32'(rd_adr_1), (c == 1) ? 32'd19 : 32'd17);
      if (c == 1) begin
        exp_q[2].push_back(32'h1002);
        exp_q[3].push_back(32'h1003);
      end else begin
        exp_q[0].push_back(32'h1000);
        exp_q[1].push_back(32'h1001);
      end
      step();
    end

    // Write then read back, p=2 so req0 is reached after wrapping.
    cyc(4'h0, 20'd0, 1'b1, 1, 32'hAAAA);
    chk("t2_wr_enb", 32'(wr_enb_0), 32'd1);
    step();
    cyc(4'b0001, adr4(0, 0, 0, 1), 1'b0, 0, 32'd0);
    chk("t2_rdy", 32'(bus.rd_req_rdy), 32'b0001);
    chk("t2_adr0", 32'(rd_adr_0), 32'd1);
    exp_q[0].push_back(32'hAAAA);
    step();

    // Same-cycle write/read of adr 8: array returns old 0x5555, response must be 0x8.
    cyc(4'h0, 20'd0, 1'b1, 8, 32'h5555);
    step();
    cyc(4'b0100, adr4(0, 8, 0, 0), 1'b1, 8, 32'h8);
    chk("t4_rdy", 32'(bus.rd_req_rdy), 32'b0100);
    chk("t4_wr_enb", 32'(wr_enb_0), 32'd1);
    exp_q[2].push_back(32'h8);
    step();
    cyc(4'b0100, adr4(0, 8, 0, 0), 1'b0, 0, 32'd0);
    exp_q[2].push_back(32'h8);
    step();

    // Both ports on adr 5 with a same-cycle write: both bypass. p=3 -> {0,1}.
    cyc(4'b0011, adr4(0, 0, 5, 5), 1'b1, 5, 32'h77);
    chk("dual_rdy", 32'(bus.rd_req_rdy), 32'b0011);
    chk("dual_adr1", 32'(rd_adr_1), 32'd5);
    chk("dual_enb1", 32'(rd_enb_1), 32'd1);
    exp_q[0].push_back(32'h77);
    exp_q[1].push_back(32'h77);
    step();

    // Two reads issued, then reset: their responses must never appear.
    cyc(4'b0011, adr4(0, 0, 17, 16), 1'b0, 0, 32'd0);
    chk("t6_rdy", 32'(bus.rd_req_rdy), 32'b0011);
    step();
    do_reset();
    init_sweep();

    // Fill left adr 17 zero; pointer back at 0 so req1 lands on port 0.
    cyc(4'b0010, adr4(0, 0, 17, 0), 1'b0, 0, 32'd0);
    chk("post_rdy", 32'(bus.rd_req_rdy), 32'b0010);
    chk("post_adr0", 32'(rd_adr_0), 32'd17);
    exp_q[1].push_back(32'd0);
    step();
    cyc(4'h0, 20'd0, 1'b0, 0, 32'd0);
    repeat (3) step();

    for (int i = 0; i < NUM_RD; i++) chk($sformatf("q_empty[%0d]", i), 32'(exp_q[i].size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
